mcycle_ctrl32: RTL and testbench

Multi-cycle sequencer for the 32-bit MIPS datapath. Decodes the instruction held in the IR and steps the shared datapath (PC, IR, A/B latches, ALU, ALUOut, MDR, register file, unified memory port) through FETCH/DECODE/EXEC/MEM/WB. It replaces per-instruction single-cycle control with one resource-sharing FSM, and handshakes with a variable-latency memory.

---
 rtl/mcycle_ctrl32.sv | 254 +++++++++++++++++++++++++
 tb/tb_mcycle_ctrl32.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_ctrl32.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_ctrl32
// Description : Multi-cycle control sequencer for a shared 32-bit MIPS
//               datapath. Decodes the IR opcode/funct and steps PC, IR, A/B,
//               ALUOut, MDR, register file and a unified variable-latency
//               memory port through FETCH/DECODE/EXEC/MEM/WB.
//
// Ports       : clock, reset        rising-edge clock, sync active-high reset
//               Opcode              IR[31:26]
//               Function_opcode     IR[5:0]
//               Zero                ALU result == 0
//               mem_ready           memory completes current request
//               mem_req, mem_we     memory request / write enable
//               pc_write .. reg_write  datapath register load strobes
//               pc_src, alu_src_a, alu_src_b, alu_op,
//               reg_dst, mem_to_reg datapath mux selects
//               state               FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//               instr_done, illegal one-cycle retire / bad-opcode pulses
//               cycle_cnt, instr_cnt performance counters
//
// Build option: MCYCLE_CTRL32_PERF_EN enables the performance counters;
//               when undefined both counter ports read 0 and no counter
//               flops exist.
//
// Revision    : 1.0  initial release
// ============================================================================
module mcycle_ctrl32 (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Function_opcode,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_write,
    output logic        ir_write,
    output logic        ab_write,
    output logic        alu_out_write,
    output logic        mdr_write,
    output logic        reg_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------
    // Instruction class decode
    // ------------------------------------------------------------------
    logic w_is_rtype, w_is_iformat, w_is_lw, w_is_sw;
    logic w_is_beq, w_is_bne, w_is_j, w_is_jal, w_is_jr, w_is_legal;

    assign w_is_rtype   = (Opcode == 6'b000000);
    assign w_is_iformat = (Opcode[5:3] == 3'b001);
    assign w_is_lw      = (Opcode == 6'b100011);
    assign w_is_sw      = (Opcode == 6'b101011);
    assign w_is_beq     = (Opcode == 6'b000100);
    assign w_is_bne     = (Opcode == 6'b000101);
    assign w_is_j       = (Opcode == 6'b000010);
    assign w_is_jal     = (Opcode == 6'b000011);
    assign w_is_jr      = w_is_rtype && (Function_opcode == 6'b001000);
    assign w_is_legal   = w_is_rtype | w_is_iformat | w_is_lw | w_is_sw |
                          w_is_beq | w_is_bne | w_is_j | w_is_jal;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state = r_state;

    // ------------------------------------------------------------------
    // Next state and control outputs. Reset holds every output at zero,
    // so a store waiting in MEM cannot write during the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        ab_write      = 1'b0;
        alu_out_write = 1'b0;
        mdr_write     = 1'b0;
        reg_write     = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    // PC+4 computed every wait cycle; loads only on completion.
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        w_next_state = S_DECODE;
                    end
                end

                S_DECODE: begin
                    alu_src_b = 2'b11;
                    if (!w_is_legal) begin
                        illegal      = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        // Latch operands and speculative branch target.
                        ab_write      = 1'b1;
                        alu_out_write = 1'b1;
                        if (w_is_j) begin
                            pc_write     = 1'b1;
                            pc_src       = 2'b10;
                            instr_done   = 1'b1;
                            w_next_state = S_FETCH;
                        end else if (w_is_jr) begin
                            pc_write     = 1'b1;
                            pc_src       = 2'b11;
                            instr_done   = 1'b1;
                            w_next_state = S_FETCH;
                        end else if (w_is_jal) begin
                            // PC still holds old PC+4 on this edge: link value.
                            pc_write     = 1'b1;
                            pc_src       = 2'b10;
                            reg_write    = 1'b1;
                            reg_dst      = 2'b10;
                            mem_to_reg   = 2'b10;
                            instr_done   = 1'b1;
                            w_next_state = S_FETCH;
                        end else begin
                            w_next_state = S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    alu_src_a = 1'b1;
                    if (w_is_beq || w_is_bne) begin
                        alu_op       = 2'b01;
                        pc_src       = 2'b01;
                        pc_write     = w_is_beq ? Zero : ~Zero;
                        instr_done   = 1'b1;
                        w_next_state = S_FETCH;
                    end else if (w_is_rtype) begin
                        alu_op        = 2'b10;
                        alu_out_write = 1'b1;
                        w_next_state  = S_WB;
                    end else if (w_is_iformat) begin
                        alu_src_b     = 2'b10;
                        alu_op        = 2'b10;
                        alu_out_write = 1'b1;
                        w_next_state  = S_WB;
                    end else if (w_is_lw || w_is_sw) begin
                        alu_src_b     = 2'b10;
                        alu_out_write = 1'b1;
                        w_next_state  = S_MEM;
                    end else begin
                        alu_src_a    = 1'b0;
                        w_next_state = S_FETCH;
                    end
                end

                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = w_is_sw;
                    if (mem_ready) begin
                        if (w_is_sw) begin
                            instr_done   = 1'b1;
                            w_next_state = S_FETCH;
                        end else begin
                            mdr_write    = 1'b1;
                            w_next_state = S_WB;
                        end
                    end
                end

                S_WB: begin
                    reg_write    = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                    if (w_is_rtype) begin
                        reg_dst = 2'b01;
                    end else if (w_is_lw) begin
                        mem_to_reg = 2'b01;
                    end
                end

                default: begin
                    w_next_state = S_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef MCYCLE_CTRL32_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle_cnt <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (instr_done) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcycle_ctrl32.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcycle_ctrl32
// Description : Directed self-checking bench for mcycle_ctrl32. Inputs change
//               on the falling edge; outputs are sampled 1 ns later.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mcycle_ctrl32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Opcode = 6'd0;
    logic [5:0]  Function_opcode = 6'd0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, pc_write, ir_write, ab_write, alu_out_write;
    logic        mdr_write, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0]  pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instr_cnt;

    int tests = 0;
    int fails = 0;
    int exp_instr = 0;

    mcycle_ctrl32 dut (
        .clock(clock), .reset(reset), .Opcode(Opcode),
        .Function_opcode(Function_opcode), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .pc_write(pc_write),
        .ir_write(ir_write), .ab_write(ab_write), .alu_out_write(alu_out_write),
        .mdr_write(mdr_write), .reg_write(reg_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .instr_done(instr_done), .illegal(illegal),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clock = ~clock;

    // {state, mem_req, mem_we, pc_write, ir_write, ab_write, alu_out_write,
    //  mdr_write, reg_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_dst,
    //  mem_to_reg, instr_done, illegal}
    wire [23:0] ctrl = {state, mem_req, mem_we, pc_write, ir_write, ab_write,
                        alu_out_write, mdr_write, reg_write, pc_src, alu_src_a,
                        alu_src_b, alu_op, reg_dst, mem_to_reg, instr_done, illegal};

    localparam logic [23:0] F_RDY  = {3'd0, 8'b1011_0000, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [23:0] F_WAIT = {3'd0, 8'b1000_0000, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [23:0] D_EX   = {3'd1, 8'b0000_1100, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [23:0] D_J    = {3'd1, 8'b0010_1100, 2'b10, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] D_JR   = {3'd1, 8'b0010_1100, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] D_JAL  = {3'd1, 8'b0010_1101, 2'b10, 1'b0, 2'b11, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0};
    localparam logic [23:0] E_R    = {3'd2, 8'b0000_0100, 2'b00, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [23:0] E_I    = {3'd2, 8'b0000_0100, 2'b00, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [23:0] E_LS   = {3'd2, 8'b0000_0100, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [23:0] E_BEQT = {3'd2, 8'b0010_0000, 2'b01, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] M_LDW  = {3'd3, 8'b1000_0000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [23:0] M_LDR  = {3'd3, 8'b1000_0010, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [23:0] M_STW  = {3'd3, 8'b1100_0000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [23:0] M_STR  = {3'd3, 8'b1100_0000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] WB_R   = {3'd4, 8'b0000_0001, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] WB_I   = {3'd4, 8'b0000_0001, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] WB_LW  = {3'd4, 8'b0000_0001, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0};

    task automatic test_reset();
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        tests++;
        if (ctrl !== 24'd0) begin
            fails++; $display("FAIL reset_ctrl got %h want %h", ctrl, 24'd0);
        end
        tests++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cycle_cnt, instr_cnt);
        end
        reset = 1'b0;
        mem_ready = 1'b0;
        exp_instr = 0;
        // First non-reset edge leaves the FSM waiting in FETCH.
        @(negedge clock); #1;
        tests++;
        if (ctrl !== F_WAIT) begin
            fails++; $display("FAIL fetch_wait got %h want %h", ctrl, F_WAIT);
        end
`ifdef MCYCLE_CTRL32_PERF_EN
        tests++;
        if (cycle_cnt !== 32'd1) begin
            fails++; $display("FAIL cycle_cnt got %0d want 1", cycle_cnt);
        end
`endif
    endtask

    task automatic test_addu();
        logic [23:0] ev [4];
        ev = '{F_RDY, D_EX, E_R, WB_R};
        Opcode = 6'b000000; Function_opcode = 6'b100001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); mem_ready = 1'b1; #1;
            tests++;
            if (ctrl !== ev[i]) begin
                fails++; $display("FAIL addu_c%0d got %h want %h", i, ctrl, ev[i]);
            end
        end
        exp_instr++;
        @(negedge clock); mem_ready = 1'b0; #1;
        tests++;
        if (ctrl !== F_WAIT) begin
            fails++; $display("FAIL addu_end got %h want %h", ctrl, F_WAIT);
        end
    endtask

    task automatic test_addi();
        logic [23:0] ev [4];
        ev = '{F_RDY, D_EX, E_I, WB_I};
        Opcode = 6'b001001; Function_opcode = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); mem_ready = 1'b1; #1;
            tests++;
            if (ctrl !== ev[i]) begin
                fails++; $display("FAIL addiu_c%0d got %h want %h", i, ctrl, ev[i]);
            end
        end
        exp_instr++;
        @(negedge clock); mem_ready = 1'b0; #1;
        tests++;
        if (state !== 3'd0) begin
            fails++; $display("FAIL addiu_end state got %0d want 0", state);
        end
    endtask

    task automatic test_lw_stall();
        logic [23:0] ev [8];
        logic [7:0]  rdy;
        ev  = '{F_RDY, D_EX, E_LS, M_LDW, M_LDW, M_LDW, M_LDR, WB_LW};
        rdy = 8'b0100_0001;       // bit i = mem_ready in cycle i
        Opcode = 6'b100011; Function_opcode = 6'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock); mem_ready = rdy[i]; #1;
            tests++;
            if (ctrl !== ev[i]) begin
                fails++; $display("FAIL lw_c%0d got %h want %h", i, ctrl, ev[i]);
            end
        end
        exp_instr++;
        @(negedge clock); mem_ready = 1'b0; #1;
        tests++;
        if (state !== 3'd0) begin
            fails++; $display("FAIL lw_end state got %0d want 0", state);
        end
    endtask

    task automatic test_branch();
        // beq taken with Zero=1
        logic [23:0] ev [3];
        ev = '{F_RDY, D_EX, E_BEQT};
        Opcode = 6'b000100; Zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); mem_ready = 1'b1; #1;
            tests++;
            if (ctrl !== ev[i]) begin
                fails++; $display("FAIL beq_c%0d got %h want %h", i, ctrl, ev[i]);
            end
        end
        exp_instr++;
        // bne with Zero=1: not taken, still retires in EXEC
        Opcode = 6'b000101;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); mem_ready = 1'b1; #1;
            tests++;
            if (ctrl !== ev[i]) begin
                fails++; $display("FAIL bne_c%0d got %h want %h", i, ctrl, ev[i]);
            end
        end
        @(negedge clock); mem_ready = 1'b0; #1;
        tests++;
        if ({state, pc_write, instr_done} !== {3'd2, 1'b0, 1'b1}) begin
            fails++; $display("FAIL bne_exec got st=%0d pcw=%b dn=%b want st=2 pcw=0 dn=1",
                              state, pc_write, instr_done);
        end
        exp_instr++;
        @(negedge clock); #1;
        tests++;
        if (state !== 3'd0) begin
            fails++; $display("FAIL bne_end state got %0d want 0", state);
        end
        Zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [23:0] ev [3];
        logic [5:0]  ops [3];
        ev  = '{D_J, D_JR, D_JAL};
        ops = '{6'b000010, 6'b000000, 6'b000011};
        Function_opcode = 6'b001000;
        for (int k = 0; k < 3; k++) begin
            Opcode = ops[k];
            @(negedge clock); mem_ready = 1'b1; #1;
            tests++;
            if (ctrl !== F_RDY) begin
                fails++; $display("FAIL jump%0d_fetch got %h want %h", k, ctrl, F_RDY);
            end
            @(negedge clock); mem_ready = 1'b0; #1;
            tests++;
            if (ctrl !== ev[k]) begin
                fails++; $display("FAIL jump%0d_decode got %h want %h", k, ctrl, ev[k]);
            end
            exp_instr++;
        end
        @(negedge clock); #1;
        tests++;
        if (ctrl !== F_WAIT) begin
            fails++; $display("FAIL jal_next got %h want %h", ctrl, F_WAIT);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] want_cnt;
`ifdef MCYCLE_CTRL32_PERF_EN
        want_cnt = exp_instr;
`else
        want_cnt = 32'd0;
`endif
        Opcode = 6'b111111; Function_opcode = 6'd0;
        @(negedge clock); mem_ready = 1'b1; #1;
        tests++;
        if (instr_cnt !== want_cnt) begin
            fails++; $display("FAIL ill_cnt_pre got %0d want %0d", instr_cnt, want_cnt);
        end
        @(negedge clock); mem_ready = 1'b0; #1;
        tests++;
        if ({state, ctrl[20:13], instr_done, illegal} !== {3'd1, 8'd0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL ill_decode got st=%0d stb=%b dn=%b il=%b want st=1 stb=0 dn=0 il=1",
                              state, ctrl[20:13], instr_done, illegal);
        end
        @(negedge clock); #1;
        tests++;
        if (ctrl !== F_WAIT) begin
            fails++; $display("FAIL ill_next got %h want %h", ctrl, F_WAIT);
        end
        tests++;
        if (instr_cnt !== want_cnt) begin
            fails++; $display("FAIL ill_cnt_post got %0d want %0d", instr_cnt, want_cnt);
        end
    endtask

    task automatic test_sw_reset();
        logic [23:0] ev [5];
        logic [4:0]  rdy;
        // Zero-wait sw first, then a stalled sw interrupted by reset.
        ev  = '{F_RDY, D_EX, E_LS, M_STR, F_WAIT};
        rdy = 5'b01001;
        Opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); mem_ready = rdy[i]; #1;
            tests++;
            if (ctrl !== ev[i]) begin
                fails++; $display("FAIL sw_c%0d got %h want %h", i, ctrl, ev[i]);
            end
        end
        exp_instr++;
        ev = '{F_RDY, D_EX, E_LS, M_STW, M_STW};
        rdy = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); mem_ready = rdy[i]; #1;
            tests++;
            if (ctrl !== ev[i]) begin
                fails++; $display("FAIL swst_c%0d got %h want %h", i, ctrl, ev[i]);
            end
        end
        @(negedge clock); reset = 1'b1; mem_ready = 1'b1; #1;
        tests++;
        if (ctrl !== {3'd3, 21'd0}) begin
            fails++; $display("FAIL sw_rst_same got %h want %h", ctrl, {3'd3, 21'd0});
        end
        @(negedge clock); reset = 1'b0; mem_ready = 1'b0; #1;
        tests++;
        if (state !== 3'd0) begin
            fails++; $display("FAIL sw_rst_state got %0d want 0", state);
        end
        tests++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            fails++; $display("FAIL sw_rst_cnt got %0d/%0d want 0/0", cycle_cnt, instr_cnt);
        end
        @(negedge clock); #1;
        tests++;
        if (ctrl !== F_WAIT) begin
            fails++; $display("FAIL sw_resume got %h want %h", ctrl, F_WAIT);
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_addi();
        test_lw_stall();
        test_branch();
        test_jumps();
        test_illegal();
        test_sw_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
